// File: rtl/regfile_bypass_sb_if.sv
// Decode/writeback bundle for the register file: read ports, write port, issue port
// and the scoreboard outputs.
interface regfile_bypass_sb_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] RA;
    logic [NUM_RD*DATA_W-1:0] BusR;
    logic [NUM_RD-1:0]        PendR;
    logic [ADDR_W-1:0]        RW;
    logic [DATA_W-1:0]        BusW;
    logic                     RegWr;
    logic                     IssueV;
    logic [ADDR_W-1:0]        IssueRd;
    logic [ADDR_W:0]          PendCount;

    modport master (
        output RA, RW, BusW, RegWr, IssueV, IssueRd,
        input  BusR, PendR, PendCount
    );

    modport slave (
        input  RA, RW, BusW, RegWr, IssueV, IssueRd,
        output BusR, PendR, PendCount
    );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Register file with N combinational read ports, one bypassed write port, a hard-wired
// zero register and a pending-write scoreboard for RAW hazard detection in decode.
module regfile_bypass_sb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 2**ADDR_W-1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic               Clk,
    input  logic               Resetl,
    regfile_bypass_sb_if.slave bus
);
    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [ADDR_W:0]   r_pend_count;

    logic              w_set;
    logic              w_clear;
    logic              w_inc;
    logic              w_dec;
    logic [DEPTH-1:0]  w_pend_nxt;
    logic [ADDR_W:0]   w_pend_count_nxt;

    assign w_set   = bus.IssueV && (bus.IssueRd != ZERO_IDX);
    assign w_clear = bus.RegWr  && (bus.RW      != ZERO_IDX);

    // Count moves only on real bit transitions; a clear loses to a set on the same index.
    assign w_inc = w_set   && !r_pend[bus.IssueRd];
    assign w_dec = w_clear &&  r_pend[bus.RW] && !(w_set && (bus.IssueRd == bus.RW));

    // NOTE: defaults first, then overrides; every path assigns the output, so no latch.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_clear) w_pend_nxt[bus.RW]      = 1'b0;
        if (w_set)   w_pend_nxt[bus.IssueRd] = 1'b1;
        w_pend_count_nxt = r_pend_count + {{ADDR_W{1'b0}}, w_inc}
                                        - {{ADDR_W{1'b0}}, w_dec};
    end

    // NOTE: the array is reset because zero-after-reset is architectural state; that
    // keeps it in flops rather than a RAM macro, which has no reset.
    always_ff @(posedge Clk or negedge Resetl) begin
        if (!Resetl) begin
            r_regs <= '{default: '0};
        end else if (w_clear) begin
            r_regs[bus.RW] <= bus.BusW;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Resetl) begin
        if (!Resetl) begin
            r_pend       <= '0;
            r_pend_count <= '0;
        end else begin
            r_pend       <= w_pend_nxt;
            r_pend_count <= w_pend_count_nxt;
        end
    end

    assign bus.PendCount = r_pend_count;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_zero;
        logic              w_byp;

        assign w_ra   = bus.RA[g*ADDR_W +: ADDR_W];
        assign w_zero = (w_ra == ZERO_IDX);
        // Bypass is gated by reset so the read buses stay at zero while reset is held.
        assign w_byp  = BYPASS && Resetl && bus.RegWr && (bus.RW == w_ra);

        assign bus.BusR[g*DATA_W +: DATA_W] = w_zero ? '0
                                            : w_byp  ? bus.BusW
                                            : r_regs[w_ra];
        assign bus.PendR[g] = !w_zero && r_pend[w_ra];
    end
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Self-checking bench: default build, a BYPASS=0 build on identical stimulus, and a
// 3-port 16x32 build, all compared against array/popcount reference models.
module tb_regfile_bypass_sb;
    logic Clk;
    logic Resetl;

    int checks;
    int failures;

    regfile_bypass_sb_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) if_a ();
    regfile_bypass_sb_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) if_b ();
    regfile_bypass_sb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3)) if_p ();

    regfile_bypass_sb #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b1)) u_dut (
        .Clk(Clk), .Resetl(Resetl), .bus(if_a.slave));
    regfile_bypass_sb #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b0)) u_nb (
        .Clk(Clk), .Resetl(Resetl), .bus(if_b.slave));
    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3)) u_p (
        .Clk(Clk), .Resetl(Resetl), .bus(if_p.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference models: plain arrays; pending count is a popcount over the array.
    logic [63:0] m_regs [32];
    bit          m_pend [32];
    logic [31:0] p_regs [16];
    bit          p_pend [16];

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
        for (int i = 0; i < 16; i++) begin p_regs[i] = '0; p_pend[i] = 0; end
    endtask

    function automatic logic [5:0] m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_pend[i];
        return 6'(n);
    endfunction

    function automatic logic [4:0] p_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += p_pend[i];
        return 5'(n);
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] ra, input bit byp);
        if (ra == 5'd31) return '0;
        if (byp && if_a.RegWr && if_a.RW == ra) return if_a.BusW;
        return m_regs[ra];
    endfunction

    function automatic logic [31:0] p_read(input logic [3:0] ra);
        if (ra == 4'd15) return '0;
        if (if_p.RegWr && if_p.RW == ra) return if_p.BusW;
        return p_regs[ra];
    endfunction

    // One rising edge: models sample the same (stable) inputs the DUTs see.
    task automatic cycle();
        @(posedge Clk);
        if (if_a.RegWr && if_a.RW != 5'd31) begin
            m_regs[if_a.RW] = if_a.BusW;
            m_pend[if_a.RW] = 0;
        end
        if (if_a.IssueV && if_a.IssueRd != 5'd31) m_pend[if_a.IssueRd] = 1;
        if (if_p.RegWr && if_p.RW != 4'd15) begin
            p_regs[if_p.RW] = if_p.BusW;
            p_pend[if_p.RW] = 0;
        end
        if (if_p.IssueV && if_p.IssueRd != 4'd15) p_pend[if_p.IssueRd] = 1;
        #1;
    endtask

    task automatic drive(input logic [4:0] ra0, ra1, rw, input logic [63:0] busw,
                         input logic regwr, iv, input logic [4:0] ird);
        if_a.RA = {ra1, ra0};  if_b.RA = {ra1, ra0};
        if_a.RW = rw;          if_b.RW = rw;
        if_a.BusW = busw;      if_b.BusW = busw;
        if_a.RegWr = regwr;    if_b.RegWr = regwr;
        if_a.IssueV = iv;      if_b.IssueV = iv;
        if_a.IssueRd = ird;    if_b.IssueRd = ird;
    endtask

    task automatic drive_p(input logic [11:0] ra, input logic [3:0] rw, input logic [31:0] busw,
                           input logic regwr, iv, input logic [3:0] ird);
        if_p.RA = ra; if_p.RW = rw; if_p.BusW = busw;
        if_p.RegWr = regwr; if_p.IssueV = iv; if_p.IssueRd = ird;
    endtask

    task automatic test_reset();
        Resetl = 1'b0;
        m_reset();
        drive(5'd3, 5'd17, 5'd3, 64'h1234, 1'b0, 1'b1, 5'd3);
        drive_p(12'h321, 4'd1, 32'h55, 1'b0, 1'b0, 4'd0);
        #3;
        checks++; if (if_a.BusR !== 128'd0) begin failures++;
            $display("FAIL reset_busr got=%h exp=0", if_a.BusR); end
        checks++; if (if_a.PendR !== 2'b00 || if_a.PendCount !== 6'd0) begin failures++;
            $display("FAIL reset_pend got=%b/%0d exp=00/0", if_a.PendR, if_a.PendCount); end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        drive(5'd3, 5'd17, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0);
        Resetl = 1'b1;
        #1;
        checks++; if (if_a.BusR !== 128'd0 || if_a.PendCount !== 6'd0 || if_p.PendCount !== 5'd0)
            begin failures++;
            $display("FAIL reset_release got=%h/%0d exp=0/0", if_a.BusR, if_a.PendCount); end
    endtask

    task automatic test_bypass();
        drive(5'd5, 5'd6, 5'd5, 64'hDEAD_BEEF, 1'b1, 1'b0, 5'd0);
        #1;
        checks++; if (if_a.BusR[63:0] !== 64'hDEAD_BEEF) begin failures++;
            $display("FAIL bypass_pre got=%h exp=%h", if_a.BusR[63:0], 64'hDEAD_BEEF); end
        checks++; if (if_b.BusR[63:0] !== 64'd0) begin failures++;
            $display("FAIL nobypass_pre got=%h exp=0", if_b.BusR[63:0]); end
        checks++; if (if_a.BusR[127:64] !== 64'd0) begin failures++;
            $display("FAIL bypass_other_port got=%h exp=0", if_a.BusR[127:64]); end
        cycle();
        drive(5'd5, 5'd6, 5'd5, 64'h0, 1'b0, 1'b0, 5'd0);
        #1;
        checks++; if (if_a.BusR[63:0] !== 64'hDEAD_BEEF || if_b.BusR[63:0] !== 64'hDEAD_BEEF)
            begin failures++;
            $display("FAIL bypass_post got=%h/%h exp=%h", if_a.BusR[63:0], if_b.BusR[63:0],
                     64'hDEAD_BEEF); end
    endtask

    task automatic test_zero_reg();
        logic [5:0] cnt0;
        cnt0 = m_count();
        drive(5'd31, 5'd5, 5'd31, '1, 1'b1, 1'b1, 5'd31);
        #1;
        checks++; if (if_a.BusR[63:0] !== 64'd0 || if_a.PendR[0] !== 1'b0) begin failures++;
            $display("FAIL zero_pre got=%h/%b exp=0/0", if_a.BusR[63:0], if_a.PendR[0]); end
        cycle();
        checks++; if (if_a.BusR[63:0] !== 64'd0 || if_b.BusR[63:0] !== 64'd0) begin failures++;
            $display("FAIL zero_post got=%h/%h exp=0", if_a.BusR[63:0], if_b.BusR[63:0]); end
        checks++; if (if_a.PendR[0] !== 1'b0 || if_a.PendCount !== cnt0) begin failures++;
            $display("FAIL zero_pend got=%b/%0d exp=0/%0d", if_a.PendR[0], if_a.PendCount, cnt0); end
        checks++; if (if_a.BusR[127:64] !== 64'hDEAD_BEEF) begin failures++;
            $display("FAIL zero_other got=%h exp=%h", if_a.BusR[127:64], 64'hDEAD_BEEF); end
    endtask

    task automatic test_scoreboard();
        drive(5'd3, 5'd7, 5'd0, 64'h0, 1'b0, 1'b1, 5'd3);
        cycle();
        drive(5'd3, 5'd7, 5'd0, 64'h0, 1'b0, 1'b1, 5'd7);
        cycle();
        drive(5'd3, 5'd7, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0);
        #1;
        checks++; if (if_a.PendCount !== 6'd2 || if_a.PendR !== 2'b11) begin failures++;
            $display("FAIL sb_issue got=%0d/%b exp=2/11", if_a.PendCount, if_a.PendR); end
        drive(5'd3, 5'd7, 5'd3, 64'h0333, 1'b1, 1'b0, 5'd0);
        #1;
        checks++; if (if_a.PendR[0] !== 1'b1) begin failures++;
            $display("FAIL sb_pend_no_bypass got=%b exp=1", if_a.PendR[0]); end
        cycle();
        drive(5'd3, 5'd7, 5'd9, 64'h0999, 1'b1, 1'b0, 5'd0);
        #1;
        checks++; if (if_a.PendR !== 2'b10 || if_a.PendCount !== 6'd1) begin failures++;
            $display("FAIL sb_retire got=%b/%0d exp=10/1", if_a.PendR, if_a.PendCount); end
        cycle();
        drive(5'd9, 5'd7, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0);
        #1;
        checks++; if (if_a.PendCount !== 6'd1 || if_a.BusR[63:0] !== 64'h0999) begin failures++;
            $display("FAIL sb_clear_idle got=%0d/%h exp=1/999", if_a.PendCount, if_a.BusR[63:0]); end
    endtask

    task automatic test_simultaneous();
        drive(5'd4, 5'd2, 5'd0, 64'h0, 1'b0, 1'b1, 5'd4);
        cycle();
        drive(5'd4, 5'd2, 5'd4, 64'hAAAA_4444, 1'b1, 1'b1, 5'd4);
        cycle();
        drive(5'd4, 5'd2, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0);
        #1;
        checks++; if (if_a.PendR[0] !== 1'b1 || if_a.PendCount !== 6'd2) begin failures++;
            $display("FAIL simul_same got=%b/%0d exp=1/2", if_a.PendR[0], if_a.PendCount); end
        checks++; if (if_b.BusR[63:0] !== 64'hAAAA_4444) begin failures++;
            $display("FAIL simul_same_data got=%h exp=%h", if_b.BusR[63:0], 64'hAAAA_4444); end
        drive(5'd4, 5'd2, 5'd4, 64'hBBBB_4444, 1'b1, 1'b1, 5'd2);
        cycle();
        drive(5'd4, 5'd2, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0);
        #1;
        checks++; if (if_a.PendR !== 2'b10 || if_a.PendCount !== 6'd2) begin failures++;
            $display("FAIL simul_diff got=%b/%0d exp=10/2", if_a.PendR, if_a.PendCount); end
    endtask

    task automatic test_random();
        logic [4:0] ra0, ra1, rw, ird, ra;
        for (int n = 0; n < 400; n++) begin
            ra0 = 5'($urandom_range(0, 31));
            ra1 = 5'($urandom_range(0, 31));
            rw  = 5'($urandom_range(0, 31));
            ird = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ra0 = rw;
            drive(ra0, ra1, rw, {$urandom, $urandom}, 1'($urandom), 1'($urandom), ird);
            #1;
            for (int p = 0; p < 2; p++) begin
                ra = (p == 0) ? ra0 : ra1;
                checks++; if (if_a.BusR[p*64 +: 64] !== m_read(ra, 1'b1) ||
                              if_b.BusR[p*64 +: 64] !== m_read(ra, 1'b0)) begin failures++;
                    $display("FAIL rand_busr n=%0d port=%0d got=%h/%h exp=%h/%h", n, p,
                             if_a.BusR[p*64 +: 64], if_b.BusR[p*64 +: 64],
                             m_read(ra, 1'b1), m_read(ra, 1'b0)); end
                checks++; if (if_a.PendR[p] !== 1'(ra != 5'd31 && m_pend[ra])) begin failures++;
                    $display("FAIL rand_pendr n=%0d port=%0d got=%b exp=%b", n, p,
                             if_a.PendR[p], (ra != 5'd31 && m_pend[ra])); end
            end
            cycle();
            checks++; if (if_a.PendCount !== m_count() || if_b.PendCount !== m_count()) begin
                failures++;
                $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, if_a.PendCount, m_count()); end
        end
        drive(5'd0, 5'd0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_params();
        logic [3:0] ra [3];
        for (int i = 0; i < 16; i++) begin
            drive_p(12'h0, 4'd0, 32'h0, 1'b0, 1'b1, 4'(i));
            cycle();
        end
        drive_p({4'd15, 4'd14, 4'd0}, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0);
        #1;
        checks++; if (if_p.PendCount !== 5'd15 || if_p.PendR !== 3'b011) begin failures++;
            $display("FAIL param_fill got=%0d/%b exp=15/011", if_p.PendCount, if_p.PendR); end
        for (int i = 1; i <= 3; i++) begin
            drive_p(12'h0, 4'(i), 32'hC0DE_0000 + 32'(i), 1'b1, 1'b0, 4'd0);
            cycle();
        end
        drive_p({4'd3, 4'd2, 4'd1}, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0);
        #1;
        checks++; if (if_p.BusR !== {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001}) begin
            failures++; $display("FAIL param_ports got=%h", if_p.BusR); end
        checks++; if (if_p.PendCount !== 5'd12 || if_p.PendR !== 3'b000) begin failures++;
            $display("FAIL param_retire got=%0d/%b exp=12/000", if_p.PendCount, if_p.PendR); end
        for (int n = 0; n < 200; n++) begin
            for (int p = 0; p < 3; p++) ra[p] = 4'($urandom_range(0, 15));
            drive_p({ra[2], ra[1], ra[0]}, 4'($urandom_range(0, 15)), $urandom,
                    1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)));
            #1;
            for (int p = 0; p < 3; p++) begin
                checks++; if (if_p.BusR[p*32 +: 32] !== p_read(ra[p]) ||
                              if_p.PendR[p] !== 1'(ra[p] != 4'd15 && p_pend[ra[p]])) begin
                    failures++;
                    $display("FAIL param_rand n=%0d port=%0d got=%h/%b exp=%h", n, p,
                             if_p.BusR[p*32 +: 32], if_p.PendR[p], p_read(ra[p])); end
            end
            cycle();
            checks++; if (if_p.PendCount !== p_count()) begin failures++;
                $display("FAIL param_count n=%0d got=%0d exp=%0d", n, if_p.PendCount, p_count()); end
        end
        drive_p(12'h0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_reset_mid();
        drive(5'd10, 5'd12, 5'd10, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 5'd12);
        cycle();
        drive(5'd10, 5'd12, 5'd10, 64'h5555_6666_7777_8888, 1'b1, 1'b0, 5'd0);
        #1;
        checks++; if (if_a.PendR[1] !== 1'b1 || if_a.PendCount === 6'd0) begin failures++;
            $display("FAIL rstmid_pre got=%b/%0d exp=1/nonzero", if_a.PendR[1], if_a.PendCount); end
        Resetl = 1'b0;
        m_reset();
        #1;
        checks++; if (if_a.PendR !== 2'b00 || if_a.PendCount !== 6'd0 ||
                      if_a.BusR[127:64] !== 64'd0 || if_p.PendCount !== 5'd0) begin failures++;
            $display("FAIL rstmid_async got=%b/%0d/%h exp=00/0/0", if_a.PendR, if_a.PendCount,
                     if_a.BusR[127:64]); end
        @(posedge Clk);
        #1;
        @(negedge Clk);
        Resetl = 1'b1;
        drive(5'd10, 5'd12, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0);
        #1;
        checks++; if (if_a.BusR !== 128'd0 || if_b.BusR !== 128'd0 || if_a.PendCount !== 6'd0)
            begin failures++;
            $display("FAIL rstmid_discard got=%h/%0d exp=0/0", if_a.BusR, if_a.PendCount); end
        cycle();
        checks++; if (if_a.BusR !== 128'd0 || if_a.PendCount !== m_count()) begin failures++;
            $display("FAIL rstmid_hold got=%h/%0d exp=0/0", if_a.BusR, if_a.PendCount); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_simultaneous();
        test_random();
        test_params();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
